chrono_ctrl: RTL and testbench

//  Stopwatch controller for the 100 ms chronometer datapath.

---
 rtl/chrono_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_chrono_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/chrono_ctrl.sv
// Stopwatch controller: debounces Start/Stop and Lap/Reset buttons, sequences a
// modulo counter advanced by the 100 ms tick and selects live or lap value for display.
module chrono_ctrl #(
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned CNT_MOD    = 256,
  parameter int unsigned DEB_WIDTH  = 16,
  parameter int unsigned DEB_CYCLES = 25000,
  parameter bit          BTN_ACTIVE = 1'b1
) (
  input  logic                 ClkIn,
  input  logic                 nRst,
  input  logic                 Tick,
  input  logic                 BtnSS,
  input  logic                 BtnLR,
  output logic [CNT_WIDTH-1:0] Count,
  output logic [CNT_WIDTH-1:0] DispValue,
  output logic                 Running,
  output logic                 LapShown,
  output logic                 Wrap
);

  localparam int unsigned NBTN   = 2;
  localparam int unsigned BTN_SS = 0;
  localparam int unsigned BTN_LR = 1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(CNT_MOD - 1);
  localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  // Button path, index 0 = Start/Stop, 1 = Lap/Reset; all levels are "pressed = 1"
  logic [NBTN-1:0]      w_raw;
  logic [NBTN-1:0]      r_s1;
  logic [NBTN-1:0]      r_s2;
  logic [NBTN-1:0]      r_lvl;
  logic [NBTN-1:0]      r_lvl_d;
  logic [NBTN-1:0]      r_pulse;
  logic [DEB_WIDTH-1:0] r_deb_cnt [NBTN];

  logic w_pss;
  logic w_plr;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_lap;
  logic [CNT_WIDTH-1:0] r_disp;
  logic                 r_running;
  logic                 r_lap_shown;
  logic                 r_wrap;

  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_lap_nxt;
  logic [CNT_WIDTH-1:0] w_disp_nxt;
  logic                 w_clr;
  logic                 w_wrap_nxt;

  assign w_raw = {BtnLR, BtnSS} ~^ {NBTN{BTN_ACTIVE}};

  // Synchronizer, stability counter, debounced level and registered press pulse
  always_ff @(posedge ClkIn or negedge nRst) begin
    if (!nRst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      r_pulse <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_lvl_d <= r_lvl;
      r_pulse <= r_lvl & ~r_lvl_d;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (r_s2[i] != r_lvl[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_lvl[i]     <= r_s2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DEB_WIDTH'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_pss = r_pulse[BTN_SS];
  assign w_plr = r_pulse[BTN_LR];

  always_ff @(posedge ClkIn or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next counter, lap and display values; Start/Stop wins over Lap/Reset
  always_comb begin
    w_state_nxt = r_state;
    w_lap_nxt   = r_lap;
    w_cnt_nxt   = r_count;
    w_clr       = 1'b0;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pss) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_pss) begin
          w_state_nxt = ST_STOP;
        end else if (w_plr) begin
          w_state_nxt = ST_LAP;
          w_lap_nxt   = r_count;
        end
      end
      ST_LAP: begin
        if (w_pss) begin
          w_state_nxt = ST_STOP;
        end else if (w_plr) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STOP: begin
        if (w_pss) begin
          w_state_nxt = ST_RUN;
        end else if (w_plr) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Counting follows the current state, so a tick on the RUN->STOP edge still counts
    if (w_clr) begin
      w_cnt_nxt = '0;
    end else if (Tick && (r_state == ST_RUN || r_state == ST_LAP)) begin
      if (r_count == CNT_MAX) begin
        w_cnt_nxt  = '0;
        w_wrap_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_count + CNT_WIDTH'(1);
      end
    end

    w_disp_nxt = (w_state_nxt == ST_LAP) ? w_lap_nxt : w_cnt_nxt;
  end

  always_ff @(posedge ClkIn or negedge nRst) begin
    if (!nRst) begin
      r_count     <= '0;
      r_lap       <= '0;
      r_disp      <= '0;
      r_running   <= 1'b0;
      r_lap_shown <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_count     <= w_cnt_nxt;
      r_lap       <= w_lap_nxt;
      r_disp      <= w_disp_nxt;
      r_running   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
      r_lap_shown <= (w_state_nxt == ST_LAP);
      r_wrap      <= w_wrap_nxt;
    end
  end

  assign Count     = r_count;
  assign DispValue = r_disp;
  assign Running   = r_running;
  assign LapShown  = r_lap_shown;
  assign Wrap      = r_wrap;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Directed bench for chrono_ctrl with short debounce (4 cycles) and modulo-10 counter.
module tb_chrono_ctrl;

  localparam int unsigned CNT_WIDTH = 8;

  logic                 ClkIn;
  logic                 nRst;
  logic                 Tick;
  logic                 BtnSS;
  logic                 BtnLR;
  logic [CNT_WIDTH-1:0] Count;
  logic [CNT_WIDTH-1:0] DispValue;
  logic                 Running;
  logic                 LapShown;
  logic                 Wrap;

  int n_checks = 0;
  int n_fail   = 0;

  chrono_ctrl #(
    .CNT_WIDTH (CNT_WIDTH),
    .CNT_MOD   (10),
    .DEB_WIDTH (16),
    .DEB_CYCLES(4),
    .BTN_ACTIVE(1'b1)
  ) dut (
    .ClkIn    (ClkIn),
    .nRst     (nRst),
    .Tick     (Tick),
    .BtnSS    (BtnSS),
    .BtnLR    (BtnLR),
    .Count    (Count),
    .DispValue(DispValue),
    .Running  (Running),
    .LapShown (LapShown),
    .Wrap     (Wrap)
  );

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 ns after the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ClkIn);
      #1;
    end
  endtask

  task automatic do_tick();
    Tick = 1'b1;
    cyc(1);
    Tick = 1'b0;
    cyc(1);
  endtask

  // Clean press: hold 10 cycles, then allow the release to settle
  task automatic press(input logic ss, input logic lr);
    BtnSS = ss;
    BtnLR = lr;
    cyc(10);
    BtnSS = 1'b0;
    BtnLR = 1'b0;
    cyc(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRst  = 1'b0;
    Tick  = 1'b0;
    BtnSS = 1'b0;
    BtnLR = 1'b0;
    #12;
    check("rst_count", Count, 0);
    check("rst_disp", DispValue, 0);
    check("rst_running", Running, 0);
    check("rst_lapshown", LapShown, 0);
    check("rst_wrap", Wrap, 0);
    @(posedge ClkIn);
    #1;
    nRst = 1'b1;
    cyc(3);

    // Lap/Reset in IDLE does nothing
    press(1'b0, 1'b1);
    check("idle_lr_running", Running, 0);

    // Clean start: RUN exactly 7 edges after first sample
    BtnSS = 1'b1;
    cyc(6);
    check("start_n5", Running, 0);
    cyc(1);
    check("start_n6", Running, 0);
    cyc(1);
    check("start_n7", Running, 1);
    cyc(2);
    BtnSS = 1'b0;
    cyc(10);
    repeat (3) do_tick();
    check("run_count3", Count, 3);
    press(1'b1, 1'b0);
    check("stop_running", Running, 0);
    check("stop_count", Count, 3);
    check("stop_disp", DispValue, 3);

    // Bounce rejected, then single transition after stable rise
    repeat (2) begin
      BtnSS = 1'b1;
      cyc(1);
      BtnSS = 1'b0;
      cyc(1);
    end
    cyc(6);
    check("bounce_running", Running, 0);
    BtnSS = 1'b1;
    cyc(6);
    check("bounce_n5", Running, 0);
    cyc(1);
    check("bounce_n6", Running, 0);
    cyc(1);
    check("bounce_n7", Running, 1);
    cyc(4);
    BtnSS = 1'b0;
    cyc(10);
    check("hold_single", Running, 1);

    // Lap freezes display while counting continues
    do_tick();
    check("pre_lap_count", Count, 4);
    press(1'b0, 1'b1);
    check("lap_shown", LapShown, 1);
    check("lap_disp", DispValue, 4);
    do_tick();
    do_tick();
    check("lap_count", Count, 6);
    check("lap_disp_frozen", DispValue, 4);
    check("lap_running", Running, 1);
    press(1'b0, 1'b1);
    check("unlap_disp", DispValue, 6);
    check("unlap_shown", LapShown, 0);

    // Back to zero via STOP + Lap/Reset, restart, then wrap through 9 -> 0
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("clr_count", Count, 0);
    check("clr_running", Running, 0);
    do_tick();
    check("idle_tick", Count, 0);
    press(1'b1, 1'b0);
    check("restart_running", Running, 1);
    for (int i = 1; i <= 12; i++) begin
      Tick = 1'b1;
      cyc(1);
      check($sformatf("wrap_count_%0d", i), Count, i % 10);
      check($sformatf("wrap_pulse_%0d", i), Wrap, (i == 10) ? 1 : 0);
      Tick = 1'b0;
      cyc(1);
      check($sformatf("wrap_low_%0d", i), Wrap, 0);
    end

    // Simultaneous presses in STOP: Start/Stop wins
    repeat (3) do_tick();
    press(1'b1, 1'b0);
    check("stop5_count", Count, 5);
    check("stop5_running", Running, 0);
    press(1'b1, 1'b1);
    check("both_running", Running, 1);
    check("both_count", Count, 5);
    check("both_lapshown", LapShown, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("final_count", Count, 0);
    check("final_disp", DispValue, 0);
    check("final_running", Running, 0);

    // Mid-run async reset, with a partially debounced press discarded
    press(1'b1, 1'b0);
    repeat (7) do_tick();
    check("pre_rst_count", Count, 7);
    BtnSS = 1'b1;
    cyc(3);
    nRst = 1'b0;
    #2;
    check("async_count", Count, 0);
    check("async_disp", DispValue, 0);
    check("async_running", Running, 0);
    #1;
    nRst = 1'b1;
    cyc(6);
    check("post_rst_n5", Running, 0);
    cyc(1);
    check("post_rst_n6", Running, 0);
    cyc(1);
    check("post_rst_n7", Running, 1);
    check("post_rst_count", Count, 0);
    BtnSS = 1'b0;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
